// File: rtl/imem_rom_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_rom_responder_if
// Description : Bus bundle between the fetch stage / boot loader and the
//               instruction ROM responder.
//               Fetch side : rom_addr -> rom_dout, addr_fault, busy
//               Loader side: load_start, load_valid, load_data, load_last
//                            -> load_ready, words_loaded, load_overflow
//               master = fetch stage + boot loader, slave = responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_rom_responder_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int CNT_W = $clog2(DEPTH_WORDS) + 1;

  logic [31:0]      rom_addr;
  logic [31:0]      rom_dout;
  logic             addr_fault;
  logic             busy;
  logic             load_start;
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_last;
  logic             load_ready;
  logic [CNT_W-1:0] words_loaded;
  logic             load_overflow;

  modport master (
    output rom_addr, load_start, load_valid, load_data, load_last,
    input  rom_dout, addr_fault, busy, load_ready, words_loaded, load_overflow
  );

  modport slave (
    input  rom_addr, load_start, load_valid, load_data, load_last,
    output rom_dout, addr_fault, busy, load_ready, words_loaded, load_overflow
  );
endinterface
`default_nettype wire

// File: rtl/imem_rom_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_rom_responder
// Description : Instruction-fetch ROM responder. Combinational word read for
//               the fetch stage; word array filled by a byte-serial boot
//               loader that assembles little-endian bytes into words.
// Ports       : clk   - clock
//               reset - synchronous, active-high
//               bus   - imem_rom_responder_if.slave (fetch + loader signals)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_rom_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          BOOT_WAIT   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  imem_rom_responder_if.slave        bus
);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = AW + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOAD = 1'b1} state_t;

  logic [31:0]      mem [DEPTH_WORDS];

  state_t           state, state_nxt;
  logic [1:0]       byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0] word_ptr, word_ptr_nxt;   // doubles as words_loaded
  logic [23:0]      asm_q, asm_nxt;           // lanes 0..2; lane 3 is taken live
  logic             ovf_q, ovf_nxt;
  logic             booted_q, booted_nxt;
  logic             busy_q, busy_nxt;

  logic             wr_en;
  logic [31:0]      wr_word;
  logic [31:0]      lane_word;
  logic             full;

  // --------------------------------------------------------------------------
  // Read path: zero latency, independent of loader state
  // --------------------------------------------------------------------------
  logic [31:0] rd_off;
  logic [31:0] rd_idx;
  logic        rd_hit;

  always_comb begin
    rd_off = bus.rom_addr - BASE_ADDR;
    rd_idx = rd_off >> 2;
    rd_hit = (bus.rom_addr >= BASE_ADDR) &&
             (rd_idx < 32'(DEPTH_WORDS)) &&
             (bus.rom_addr[1:0] == 2'b00);
    bus.rom_dout   = rd_hit ? mem[rd_idx[AW-1:0]] : 32'h0000_0000;
    bus.addr_fault = !rd_hit;
  end

  // --------------------------------------------------------------------------
  // Loader FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_cnt <= 2'd0;
      word_ptr <= '0;
      asm_q    <= 24'h0;
      ovf_q    <= 1'b0;
      booted_q <= 1'b0;
      busy_q   <= (BOOT_WAIT != 0);
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      word_ptr <= word_ptr_nxt;
      asm_q    <= asm_nxt;
      ovf_q    <= ovf_nxt;
      booted_q <= booted_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // Array is deliberately outside the reset domain so an image survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_ptr[AW-1:0]] <= wr_word;
    end
  end

  // --------------------------------------------------------------------------
  // Loader FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    word_ptr_nxt = word_ptr;
    asm_nxt      = asm_q;
    ovf_nxt      = ovf_q;
    booted_nxt   = booted_q;
    wr_en        = 1'b0;
    full         = (word_ptr == CNT_W'(DEPTH_WORDS));
    // Lanes above byte_cnt in asm_q are always zero, so OR-ing the new byte
    // in its lane yields the zero-padded word for a short final word.
    lane_word    = {24'h0, bus.load_data} << {byte_cnt, 3'b000};
    wr_word      = {8'h00, asm_q} | lane_word;

    unique case (state)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_nxt    = ST_LOAD;
          byte_cnt_nxt = 2'd0;
          word_ptr_nxt = '0;
          asm_nxt      = 24'h0;
          ovf_nxt      = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.load_start) begin
          // Restart wins over a byte presented in the same cycle.
          byte_cnt_nxt = 2'd0;
          word_ptr_nxt = '0;
          asm_nxt      = 24'h0;
          ovf_nxt      = 1'b0;
        end else if (bus.load_valid) begin
          if (full) begin
            ovf_nxt = 1'b1;
          end else if (byte_cnt == 2'd3 || bus.load_last) begin
            wr_en        = 1'b1;
            word_ptr_nxt = word_ptr + CNT_W'(1);
            byte_cnt_nxt = 2'd0;
            asm_nxt      = 24'h0;
          end else begin
            asm_nxt      = wr_word[23:0];
            byte_cnt_nxt = byte_cnt + 2'd1;
          end
          if (bus.load_last) begin
            state_nxt  = ST_IDLE;
            booted_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_LOAD) || ((BOOT_WAIT != 0) && !booted_nxt);
  end

  assign bus.busy          = busy_q;
  assign bus.load_ready    = (state == ST_LOAD);
  assign bus.words_loaded  = word_ptr;
  assign bus.load_overflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_imem_rom_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_rom_responder
// Description : Self-checking bench for imem_rom_responder (DEPTH_WORDS=4,
//               BOOT_WAIT=1). Byte images are turned into expected words by a
//               reference model that slices the byte list into 4-byte groups.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_rom_responder;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_rom_responder_if #(.DEPTH_WORDS(DEPTH)) bus ();

  imem_rom_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .BOOT_WAIT  (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem   [DEPTH];
  bit          m_valid [DEPTH];
  int          m_words = 0;
  bit          m_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A session writes every complete 4-byte group; if it ended with load_last
  // the trailing partial group is written zero-padded. Nothing beyond DEPTH.
  function automatic void model_session(input logic [7:0] q[$], input bit complete);
    int n  = q.size();
    int nw = complete ? (n + 3) / 4 : n / 4;
    for (int w = 0; w < nw && w < DEPTH; w++) begin
      logic [31:0] word = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < n) word |= 32'(q[4 * w + j]) << (8 * j);
      m_mem[w]   = word;
      m_valid[w] = 1'b1;
    end
    m_words = (nw < DEPTH) ? nw : DEPTH;
    m_ovf   = complete && (n > 4 * DEPTH);
  endfunction

  task automatic start_pulse(input bit with_byte);
    bus.load_start = 1'b1;
    bus.load_valid = with_byte;
    bus.load_data  = 8'hEE;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit gaps, input bit mark_last);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < g; k++) begin
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b1;
        bus.load_data  = 8'($urandom);
        tick();
      end
      bus.load_valid = 1'b1;
      bus.load_data  = q[i];
      bus.load_last  = mark_last && (i == q.size() - 1);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] q[$], input bit gaps, input bit start_byte);
    start_pulse(start_byte);
    check("busy_in_load", 32'(bus.busy), 32'd1);
    check("ready_in_load", 32'(bus.load_ready), 32'd1);
    send_bytes(q, gaps, 1'b1);
    model_session(q, 1'b1);
    check("busy_after_last", 32'(bus.busy), 32'd0);
    check("ready_after_last", 32'(bus.load_ready), 32'd0);
    check("words_loaded", 32'(bus.words_loaded), 32'(m_words));
    check("load_overflow", 32'(bus.load_overflow), 32'(m_ovf));
  endtask

  task automatic read_check(input logic [31:0] addr);
    logic [31:0] off = addr - BASE;
    bit hit = (addr >= BASE) && (off < 4 * DEPTH) && (addr[1:0] == 2'b00);
    bus.rom_addr = addr;
    #1;
    if (!hit) begin
      check("fault_dout", bus.rom_dout, 32'h0);
      check("fault_flag", 32'(bus.addr_fault), 32'd1);
    end else if (m_valid[off / 4]) begin
      check("read_dout", bus.rom_dout, m_mem[off / 4]);
      check("read_fault", 32'(bus.addr_fault), 32'd0);
    end
  endtask

  task automatic check_all_mem();
    for (int w = 0; w < DEPTH; w++) read_check(BASE + 32'(4 * w));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] pre[$];
    int n;

    bus.rom_addr   = BASE;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    for (int w = 0; w < DEPTH; w++) m_valid[w] = 1'b0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ready", 32'(bus.load_ready), 32'd0);
    check("rst_words", 32'(bus.words_loaded), 32'd0);
    check("rst_ovf", 32'(bus.load_overflow), 32'd0);

    // Bytes offered while IDLE are ignored
    bus.load_valid = 1'b1; bus.load_last = 1'b1; bus.load_data = 8'h5A;
    tick(); tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    check("idle_words", 32'(bus.words_loaded), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd1);

    // Two full words
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(q, 1'b0, 1'b0);
    bus.rom_addr = 32'h0040_0004; #1;
    check("word1_const", bus.rom_dout, 32'h8877_6655);
    check("word1_fault", 32'(bus.addr_fault), 32'd0);
    bus.rom_addr = 32'h0040_0000; #1;
    check("word0_const", bus.rom_dout, 32'h4433_2211);
    check_all_mem();

    // Fault addresses
    read_check(32'h003F_FFFC);
    read_check(32'h0040_0002);
    read_check(BASE + 32'(4 * DEPTH));
    read_check(32'hFFFF_FFFC);
    read_check(32'h0000_0000);

    // Partial final word
    q = '{8'hAA, 8'hBB};
    do_load(q, 1'b0, 1'b0);
    bus.rom_addr = BASE; #1;
    check("partial_const", bus.rom_dout, 32'h0000_BBAA);
    check_all_mem();

    // Restart after 3 bytes; restart pulse carries a byte that must be dropped
    pre = '{8'hC1, 8'hC2, 8'hC3};
    start_pulse(1'b0);
    send_bytes(pre, 1'b0, 1'b0);
    model_session(pre, 1'b0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(q, 1'b0, 1'b1);
    bus.rom_addr = BASE; #1;
    check("restart_const", bus.rom_dout, 32'h0403_0201);

    // Same image with valid gaps
    do_load(q, 1'b1, 1'b0);
    bus.rom_addr = BASE; #1;
    check("gaps_const", bus.rom_dout, 32'h0403_0201);
    check_all_mem();

    // Randomized sessions, some with an aborted prefix
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pre = {};
        n = $urandom_range(1, 9);
        for (int i = 0; i < n; i++) pre.push_back(8'($urandom));
        start_pulse(1'b0);
        send_bytes(pre, 1'b1, 1'b0);
        model_session(pre, 1'b0);
      end
      q = {};
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_load(q, 1'b1, 1'($urandom));
      check_all_mem();
      for (int r = 0; r < 4; r++) read_check(BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 12)));
    end

    // Overflow: 20 bytes into a 4-word array
    q = {};
    for (int i = 1; i <= 20; i++) q.push_back(8'(i));
    do_load(q, 1'b0, 1'b0);
    check("ovf_words", 32'(bus.words_loaded), 32'd4);
    check("ovf_flag", 32'(bus.load_overflow), 32'd1);
    bus.rom_addr = BASE + 32'd12; #1;
    check("ovf_word3", bus.rom_dout, 32'h100F_0E0D);
    check_all_mem();

    // Reset in the middle of a load after 6 bytes
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    start_pulse(1'b0);
    send_bytes(q, 1'b0, 1'b0);
    model_session(q, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd1);
    check("midrst_ready", 32'(bus.load_ready), 32'd0);
    check("midrst_words", 32'(bus.words_loaded), 32'd0);
    check("midrst_ovf", 32'(bus.load_overflow), 32'd0);
    check_all_mem();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/imem_rom_responder.md
Name: imem_rom_responder

Overview:
Responder end of the instruction-fetch memory interface. It answers the fetch stage's word address with instruction data in the same cycle. Its word array is filled by a byte-serial boot loader (valid/ready) with a word-assembly state machine. It holds the fetch stage stalled via busy while a program image is streaming in.

Parameters:
BASE_ADDR, 32'h0040_0000, byte address of word 0; equals the fetch stage PC reset vector
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 4
BOOT_WAIT, 1, 1 = busy asserted from reset until the first load completes; 0 = busy only during LOAD

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rom_addr  in  32  byte address from fetch stage
rom_dout  out  32  instruction word, combinational from rom_addr
addr_fault  out  1  combinational; rom_addr misaligned or outside the array
busy  out  1  registered; fetch must stall while high
load_start  in  1  pulse; begin (or restart) image load at word 0
load_valid  in  1  byte strobe
load_data  in  8  image byte; little-endian, first byte -> bits 7:0
load_last  in  1  qualifies the final byte of the image (sampled with load_valid)
load_ready  out  1  high only in LOAD
words_loaded  out  $clog2(DEPTH_WORDS)+1  words written by the last/current load
load_overflow  out  1  sticky; bytes dropped because the array was full

Behaviour:
- Clock and reset: clk is the clock. reset is synchronous and active-high.
- Reset values:
  - state = IDLE, byte_cnt = 0, word_ptr = 0, assembly reg = 0
  - words_loaded = 0, load_overflow = 0, booted = 0
  - busy = BOOT_WAIT
  - Array contents are not reset and survive reset, including a reset mid-load.
- Read path (pure combinational, zero latency, valid in every state):
  - idx = (rom_addr - BASE_ADDR) >> 2, computed in 32 bits.
  - hit = (rom_addr >= BASE_ADDR) && (idx < DEPTH_WORDS) && (rom_addr[1:0] == 0).
  - hit: rom_dout = mem[idx], addr_fault = 0.
  - Otherwise: rom_dout = 32'h0000_0000, addr_fault = 1.
  - Read of a word being written this cycle returns the old contents; the write lands at the clock edge.
- States:
  - IDLE:
    - load_ready = 0; load_valid is ignored.
    - load_start -> LOAD with word_ptr = 0, byte_cnt = 0, words_loaded = 0, load_overflow = 0, busy = 1.
  - LOAD:
    - load_ready = 1, busy = 1.
    - Each accepted byte (load_valid) goes into lane byte_cnt of the assembly reg; byte_cnt++.
    - On byte_cnt == 3, or load_last:
      - Write the assembled word, with unfilled upper lanes zero, to mem[word_ptr].
      - word_ptr++, words_loaded++, byte_cnt = 0.
    - load_last -> IDLE; set booted = 1; busy = 0 next cycle.
    - load_start in LOAD restarts: pointers and counters cleared, partial word discarded. load_start takes priority over a same-cycle byte.
    - Full array (word_ptr == DEPTH_WORDS):
      - Accepted bytes are discarded and load_overflow is set.
      - load_last still returns to IDLE.
      - words_loaded saturates at DEPTH_WORDS.
- busy:
  - 1 in LOAD.
  - In IDLE: (BOOT_WAIT && !booted).
  - booted is cleared only by reset.
- Writes occur only in LOAD; no other write path exists.

Test Plan:
- Reset, BOOT_WAIT=1 -> busy=1, load_ready=0, words_loaded=0. Stream 8 bytes 0x11..0x88 with load_last on the 8th -> mem[0]=32'h4433_2211, mem[1]=32'h8877_6655, words_loaded=2, busy=0 one cycle after last. rom_addr=32'h0040_0004 -> rom_dout=32'h8877_6655, addr_fault=0.
- Partial word: bytes 0xAA, 0xBB with load_last on the 2nd -> mem[0]=32'h0000_BBAA, words_loaded=1.
- Faults:
  - rom_addr=32'h003F_FFFC -> rom_dout=0, addr_fault=1.
  - rom_addr=32'h0040_0002 -> rom_dout=0, addr_fault=1.
  - rom_addr=BASE_ADDR+4*DEPTH_WORDS -> rom_dout=0, addr_fault=1.
- Overflow with DEPTH_WORDS=4: 20 bytes, last flagged -> words_loaded=4, load_overflow=1, mem[3] holds bytes 13..16, state returns to IDLE.
- Restart/stall and valid gaps:
  - 3 bytes, then load_start, then 4 bytes 0x01..0x04 with last -> mem[0]=32'h0403_0201, words_loaded=1.
  - load_valid toggled with gaps -> same result.
- Reset mid-load after 6 bytes -> state IDLE, busy=BOOT_WAIT, mem[0] retains the word written before reset, words_loaded=0.
